shift_serdes: RTL and testbench

//   Parametrised full-duplex shift engine: parallel-loads a WIDTH-bit word,

---
 rtl/shift_serdes_if.sv | 24 ++
 rtl/shift_serdes.sv | 92 +++++++++
 tb/tb_shift_serdes.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_serdes_if.sv
// rtl/shift_serdes_if.sv - load handshake, serial pins and captured-word outputs of shift_serdes
interface shift_serdes_if #(
    parameter int WIDTH = 8
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] par_in;
    logic             shift_en;
    logic             ser_in;
    logic             ser_out;
    logic             ser_valid;
    logic [WIDTH-1:0] par_out;
    logic             out_valid;

    modport master (
        output load_valid, par_in, shift_en, ser_in,
        input  load_ready, ser_out, ser_valid, par_out, out_valid
    );

    modport slave (
        input  load_valid, par_in, shift_en, ser_in,
        output load_ready, ser_out, ser_valid, par_out, out_valid
    );
endinterface

// File: rtl/shift_serdes.sv
// rtl/shift_serdes.sv - full-duplex parallel/serial shift engine with load handshake and stall
module shift_serdes #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    shift_serdes_if.slave        bus
);
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] par_out_q, par_out_d;
    logic             out_valid_q, out_valid_d;

    logic [WIDTH-1:0] shifted;
    logic             last;
    logic             accept;

    assign last   = (state_q == SHIFT) && bus.shift_en && (cnt_q == CNT_W'(WIDTH - 1));
    assign accept = bus.load_valid && bus.load_ready;

    always_comb begin
        if (MSB_FIRST != 0) begin
            shifted = {shreg_q[WIDTH-2:0], bus.ser_in};
        end else begin
            shifted = {bus.ser_in, shreg_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        par_out_d   = par_out_q;
        out_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    shreg_d = bus.par_in;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            default: begin
                if (bus.shift_en) begin
                    shreg_d = shifted;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
                // A load on the final shift starts the next frame with no idle gap.
                if (last) begin
                    par_out_d   = shifted;
                    out_valid_d = 1'b1;
                    cnt_d       = '0;
                    if (accept) begin
                        shreg_d = bus.par_in;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            cnt_q       <= '0;
            par_out_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            par_out_q   <= par_out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.load_ready = (state_q == IDLE) || last;
    assign bus.ser_valid  = (state_q == SHIFT);
    assign bus.ser_out    = (state_q == SHIFT) ?
                            ((MSB_FIRST != 0) ? shreg_q[WIDTH-1] : shreg_q[0]) : 1'b0;
    assign bus.par_out    = par_out_q;
    assign bus.out_valid  = out_valid_q;
endmodule

// File: tb/tb_shift_serdes.sv
// tb/tb_shift_serdes.sv - bench for shift_serdes, MSB-first and LSB-first instances side by side
module tb_shift_serdes;
    localparam int W = 8;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    shift_serdes_if #(.WIDTH(W)) mif ();
    shift_serdes_if #(.WIDTH(W)) lif ();

    shift_serdes #(.WIDTH(W), .MSB_FIRST(1)) dut_msb (.clk(clk), .rst(rst), .bus(mif));
    shift_serdes #(.WIDTH(W), .MSB_FIRST(0)) dut_lsb (.clk(clk), .rst(rst), .bus(lif));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         sel;
        logic       lv;
        logic [7:0] par;
        logic       se;
        logic       si;
        logic       eso;
        logic       esv;
        logic       elr;
        logic       eov;
        logic [7:0] epo;
    } vec_t;

    vec_t tbl[22];

    // Frame-level reference: which word is in flight, how many bits sent, bits received so far.
    logic       m_active[2];
    int         m_k[2];
    logic [7:0] m_tx[2];
    logic [7:0] m_rx[2];
    logic [7:0] m_par[2];
    logic       m_ov[2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input int s, input logic lv, input logic [7:0] p,
                         input logic se, input logic si);
        if (s == 0) begin
            mif.load_valid = lv; mif.par_in = p; mif.shift_en = se; mif.ser_in = si;
        end else begin
            lif.load_valid = lv; lif.par_in = p; lif.shift_en = se; lif.ser_in = si;
        end
    endtask

    task automatic sample(input int s, output logic so, output logic sv, output logic lr,
                          output logic ov, output logic [7:0] po);
        if (s == 0) begin
            so = mif.ser_out; sv = mif.ser_valid; lr = mif.load_ready;
            ov = mif.out_valid; po = mif.par_out;
        end else begin
            so = lif.ser_out; sv = lif.ser_valid; lr = lif.load_ready;
            ov = lif.out_valid; po = lif.par_out;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 1'b0, 8'h00, 1'b0, 1'b0);
        drive(1, 1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
    endtask

    function automatic int bitpos(input int s, input int k);
        return (s == 0) ? (W - 1 - k) : k;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            m_active[s] = 1'b0; m_k[s] = 0; m_tx[s] = '0; m_rx[s] = '0;
            m_par[s] = '0; m_ov[s] = 1'b0;
        end
    endtask

    task automatic model_step(input int s, input logic r, input logic lv, input logic [7:0] p,
                              input logic se, input logic si);
        logic lst;
        logic acc;
        lst = m_active[s] && se && (m_k[s] == W - 1);
        acc = lv && (!m_active[s] || lst);
        if (r) begin
            m_active[s] = 1'b0; m_k[s] = 0; m_par[s] = '0; m_ov[s] = 1'b0;
        end else begin
            m_ov[s] = 1'b0;
            if (m_active[s] && se) begin
                m_rx[s][bitpos(s, m_k[s])] = si;
                m_k[s]++;
            end
            if (lst) begin
                m_par[s] = m_rx[s];
                m_ov[s]  = 1'b1;
                m_k[s]   = 0;
                if (acc) begin
                    m_tx[s] = p; m_rx[s] = '0;
                end else begin
                    m_active[s] = 1'b0;
                end
            end else if (!m_active[s] && acc) begin
                m_tx[s] = p; m_rx[s] = '0; m_k[s] = 0; m_active[s] = 1'b1;
            end
        end
    endtask

    initial begin
        logic       so, sv, lr, ov;
        logic [7:0] po;
        logic [7:0] w;
        logic       b;
        logic       r_lv[2], r_se[2], r_si[2];
        logic [7:0] r_par[2];
        logic       r_rst;

        checks   = 0;
        failures = 0;

        // MSB-first 0xA5 in loopback, then LSB-first 0x01 with ser_in held high.
        tbl[0]  = '{0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl[1]  = '{0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[2]  = '{0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[3]  = '{0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[4]  = '{0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[5]  = '{0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[6]  = '{0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[7]  = '{0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[8]  = '{0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00};
        tbl[9]  = '{0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5};
        tbl[10] = '{0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5};
        tbl[11] = '{1, 1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl[12] = '{1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
        for (int i = 13; i < 19; i++)
            tbl[i] = '{1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[19] = '{1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
        tbl[20] = '{1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hFF};
        tbl[21] = '{1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hFF};

        rst = 1'b1;
        drive(0, 1'b1, 8'hFF, 1'b1, 1'b1);
        drive(1, 1'b1, 8'hFF, 1'b1, 1'b1);
        tick();
        tick();
        rst = 1'b0;
        drive(0, 1'b0, 8'h00, 1'b0, 1'b0);
        drive(1, 1'b0, 8'h00, 1'b0, 1'b0);
        #1;
        for (int s = 0; s < 2; s++) begin
            sample(s, so, sv, lr, ov, po);
            chk($sformatf("reset[%0d].ser_out", s), 32'(so), 32'd0);
            chk($sformatf("reset[%0d].ser_valid", s), 32'(sv), 32'd0);
            chk($sformatf("reset[%0d].load_ready", s), 32'(lr), 32'd1);
            chk($sformatf("reset[%0d].out_valid", s), 32'(ov), 32'd0);
            chk($sformatf("reset[%0d].par_out", s), 32'(po), 32'd0);
        end
        tick();

        for (int i = 0; i < 22; i++) begin
            if (i == 0 || i == 11) do_reset();
            drive(tbl[i].sel, tbl[i].lv, tbl[i].par, tbl[i].se, tbl[i].si);
            #1;
            sample(tbl[i].sel, so, sv, lr, ov, po);
            chk($sformatf("tbl[%0d].ser_out", i), 32'(so), 32'(tbl[i].eso));
            chk($sformatf("tbl[%0d].ser_valid", i), 32'(sv), 32'(tbl[i].esv));
            chk($sformatf("tbl[%0d].load_ready", i), 32'(lr), 32'(tbl[i].elr));
            chk($sformatf("tbl[%0d].out_valid", i), 32'(ov), 32'(tbl[i].eov));
            chk($sformatf("tbl[%0d].par_out", i), 32'(po), 32'(tbl[i].epo));
            tick();
        end

        // Stall on every other cycle: each bit held two cycles.
        do_reset();
        w = 8'hA5;
        drive(0, 1'b1, w, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 16; i++) begin
            drive(0, 1'b0, 8'h00, 1'((i % 2) == 1), 1'b0);
            #1;
            sample(0, so, sv, lr, ov, po);
            chk($sformatf("stall[%0d].ser_valid", i), 32'(sv), 32'd1);
            chk($sformatf("stall[%0d].ser_out", i), 32'(so), 32'(w[7 - i / 2]));
            tick();
        end
        drive(0, 1'b0, 8'h00, 1'b0, 1'b0);
        #1;
        sample(0, so, sv, lr, ov, po);
        chk("stall.end.ser_valid", 32'(sv), 32'd0);
        chk("stall.end.out_valid", 32'(ov), 32'd1);
        chk("stall.end.par_out", 32'(po), 32'd0);
        tick();

        // Back-to-back frames with load_valid held through the first frame.
        do_reset();
        drive(0, 1'b1, 8'h3C, 1'b1, 1'b0);
        tick();
        for (int i = 0; i < 16; i++) begin
            w = (i < 8) ? 8'h3C : 8'hC3;
            b = w[7 - (i % 8)];
            drive(0, 1'(i < 8), 8'hC3, 1'b1, b);
            #1;
            sample(0, so, sv, lr, ov, po);
            chk($sformatf("b2b[%0d].ser_valid", i), 32'(sv), 32'd1);
            chk($sformatf("b2b[%0d].ser_out", i), 32'(so), 32'(b));
            chk($sformatf("b2b[%0d].load_ready", i), 32'(lr), 32'(i == 7 || i == 15));
            chk($sformatf("b2b[%0d].out_valid", i), 32'(ov), 32'(i == 8));
            if (i == 8) chk("b2b.first.par_out", 32'(po), 32'h3C);
            tick();
        end
        drive(0, 1'b0, 8'h00, 1'b0, 1'b0);
        #1;
        sample(0, so, sv, lr, ov, po);
        chk("b2b.end.ser_valid", 32'(sv), 32'd0);
        chk("b2b.end.out_valid", 32'(ov), 32'd1);
        chk("b2b.end.par_out", 32'(po), 32'hC3);
        tick();

        // Reset after the fourth shift aborts the frame and clears par_out.
        drive(0, 1'b1, 8'hA5, 1'b1, 1'b1);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(0, 1'b0, 8'h00, 1'b1, 1'b1);
            tick();
        end
        rst = 1'b1;
        drive(0, 1'b1, 8'h5A, 1'b1, 1'b1);
        tick();
        rst = 1'b0;
        drive(0, 1'b0, 8'h00, 1'b1, 1'b1);
        #1;
        sample(0, so, sv, lr, ov, po);
        chk("abort.ser_valid", 32'(sv), 32'd0);
        chk("abort.ser_out", 32'(so), 32'd0);
        chk("abort.load_ready", 32'(lr), 32'd1);
        chk("abort.par_out", 32'(po), 32'd0);
        chk("abort.out_valid", 32'(ov), 32'd0);
        tick();
        drive(0, 1'b0, 8'h00, 1'b0, 1'b0);
        #1;
        sample(0, so, sv, lr, ov, po);
        chk("abort.after.ser_valid", 32'(sv), 32'd0);
        chk("abort.after.out_valid", 32'(ov), 32'd0);
        tick();

        // Random traffic on both instances against the frame-level model.
        do_reset();
        model_reset();
        for (int c = 0; c < 600; c++) begin
            r_rst = ($urandom_range(0, 49) == 0);
            rst = r_rst;
            for (int s = 0; s < 2; s++) begin
                r_lv[s]  = 1'($urandom_range(0, 1));
                r_se[s]  = ($urandom_range(0, 3) != 0);
                r_si[s]  = 1'($urandom_range(0, 1));
                r_par[s] = 8'($urandom);
                drive(s, r_lv[s], r_par[s], r_se[s], r_si[s]);
            end
            #1;
            for (int s = 0; s < 2; s++) begin
                sample(s, so, sv, lr, ov, po);
                chk($sformatf("rnd[%0d][%0d].ser_valid", c, s), 32'(sv), 32'(m_active[s]));
                chk($sformatf("rnd[%0d][%0d].ser_out", c, s), 32'(so),
                    32'(m_active[s] ? m_tx[s][bitpos(s, m_k[s])] : 1'b0));
                chk($sformatf("rnd[%0d][%0d].load_ready", c, s), 32'(lr),
                    32'(!m_active[s] || (r_se[s] && m_k[s] == W - 1)));
                chk($sformatf("rnd[%0d][%0d].out_valid", c, s), 32'(ov), 32'(m_ov[s]));
                chk($sformatf("rnd[%0d][%0d].par_out", c, s), 32'(po), 32'(m_par[s]));
                model_step(s, r_rst, r_lv[s], r_par[s], r_se[s], r_si[s]);
            end
            tick();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
